mul_issue_scheduler: RTL
========================

Name: mul_issue_scheduler

Overview:
- Issue/hazard controller for the 4-register pipelined M-extension multiplier.
- Decides when a decoded M-type instruction enters the multiplier, and tracks in-flight destination registers in a shift scoreboard aligned to the multiplier stages.
- Stalls decode on RAW/WAW hazards and arbitrates the single writeback port between multiplier and ALU results, with the multiplier having priority.
- Provides a drain handshake so fence/CSR logic can wait for the multiplier to empty.

Parameters:
- MUL_STAGES, 4, number of multiplier stage registers; result is valid MUL_STAGES cycles after issue.
- REG_ADDR_W, 5, architectural register index width.
- CNT_W, 3, width of the in-flight counter; must hold MUL_STAGES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- dec_valid_i  in  1  decode stage holds a valid instruction.
- dec_is_m_i  in  1  instruction is M-type (multiplier class).
- dec_rd_i  in  REG_ADDR_W  destination register.
- dec_wr_i  in  1  instruction writes rd.
- dec_rs1_i  in  REG_ADDR_W  source 1 index.
- dec_rs2_i  in  REG_ADDR_W  source 2 index.
- dec_use_rs1_i  in  1  rs1 is read.
- dec_use_rs2_i  in  1  rs2 is read.
- dec_stall_o  out  1  hold decode this cycle.
- mul_issue_o  out  1  present the decode instruction to the multiplier as valid this cycle.
- mul_done_i  in  1  multiplier last-stage result valid.
- alu_wb_valid_i  in  1  ALU result requests writeback.
- alu_wb_stall_o  out  1  ALU writeback refused this cycle; ALU holds its result.
- wb_sel_mul_o  out  1  writeback mux selects the multiplier.
- wb_rd_o  out  REG_ADDR_W  rd of the retiring multiplier result.
- drain_req_i  in  1  level request: stop issuing, empty the multiplier.
- drain_done_o  out  1  one-cycle pulse when drained.
- inflight_o  out  CNT_W  multiplier instructions in flight.
- sync_err_o  out  1  sticky: mul_done_i disagreed with the scoreboard.

Behaviour:
- Reset values: scoreboard entries invalid, inflight_o=0, FSM=IDLE, sync_err_o=0. All outputs are 0 while rst=1.
- Scoreboard: MUL_STAGES entries {v, rd}.
  - Every cycle, sb[0] <= {mul_issue_o & dec_wr_i, dec_rd_i} and sb[i] <= sb[i-1]. No hold: the multiplier stall is tied off.
  - sb[MUL_STAGES-1] is the entry retiring this cycle.
- Latency: issue at cycle t gives mul_done_i at t+MUL_STAGES. Back-to-back issue is allowed every cycle.
- Hazard (all combinational; rd=x0 never matches and never sets v):
  - RAW when an in-use rs equals any valid sb[i].rd, including the retiring entry (no bypass).
  - WAW when dec_wr_i and dec_rd_i equals any valid sb[i].rd.
  - Structural: a non-M instruction stalls if issuing it now would collide at writeback. This is handled via the ALU stall below; decode is not stalled for it.
- Issue: mul_issue_o = dec_valid_i & dec_is_m_i & !hazard & (state!=DRAIN).
- Decode stall: dec_stall_o = dec_valid_i & (hazard | (dec_is_m_i & state==DRAIN)).
- Writeback:
  - When mul_done_i=1: wb_sel_mul_o=1, wb_rd_o=sb[last].rd, and alu_wb_stall_o=alu_wb_valid_i.
  - Otherwise wb_sel_mul_o=0 and alu_wb_stall_o=0.
- inflight_o: +1 on issue, -1 on mul_done_i, unchanged on both together. It must never exceed MUL_STAGES.
- FSM:
  - IDLE -> BUSY on issue.
  - BUSY -> IDLE when inflight reaches 0 with no new issue.
  - IDLE/BUSY -> DRAIN on drain_req_i. In DRAIN, no issue is allowed.
  - DRAIN -> DONE when inflight=0 at clock edge. DONE asserts drain_done_o for exactly one cycle.
  - DONE -> IDLE if drain_req_i=0, else stays in DRAIN-equivalent hold (no issue, drain_done_o low) until drain_req_i drops.
- Drain with nothing in flight: drain_done_o fires 1 cycle after drain_req_i rises.
- Sync check: if mul_done_i != sb[last].v in any cycle, sync_err_o sets and holds until rst.
- Reset mid-operation: scoreboard and counter clear immediately (asynchronous). Results still inside the multiplier are discarded by the multiplier's own reset.

Decomposition:
- structure_pkg: sb_entry_t {v, rd}, sched_state_e {IDLE, BUSY, DRAIN, DONE}.
- constants_pkg: MUL_STAGES default, REG_ADDR_W.
- One sub-module, mul_scoreboard: the shift register plus the match logic. It returns rs1_hit, rs2_hit, rd_hit and the retiring entry.
- The FSM, counter and arbitration stay in the top.

Test Plan:
- Issue MUL rd=x5 at t=0, then ADD reading x5 at t=1 -> dec_stall_o=1 for t=1..4, mul_done_i/wb_sel_mul_o=1 with wb_rd_o=5 at t=4, ADD proceeds t=5.
- Four back-to-back MULs rd=x1..x4 -> inflight_o reaches 4, retire order 1,2,3,4 at t=4..7, inflight_o returns to 0 at t=8, FSM back to IDLE.
- mul_done_i and alu_wb_valid_i both high -> wb_sel_mul_o=1, alu_wb_stall_o=1; next cycle with no mul_done_i -> ALU accepted.
- drain_req_i at t=1 after MUL at t=0 -> a MUL at decode t=1..4 is stalled, drain_done_o pulse at t=5, issue resumes after drain_req_i low.
- MUL with rd=x0, then an instruction reading x0 -> no stall, sb entry invalid, nothing written back.
- Force mul_done_i=1 with empty scoreboard -> sync_err_o=1 and stays 1; assert rst -> sync_err_o=0 immediately.

Source files
------------

// File: rtl/mul_issue_scheduler_pkg.sv
// mul_issue_scheduler_pkg: shared defaults and scheduler state encodings
package mul_issue_scheduler_pkg;
  localparam int MUL_STAGES_DEF = 4;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BUSY = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  // Post-pulse wait for drain_req_i to drop; blocks issue like DRAIN.
  localparam logic [2:0] ST_HOLD = 3'd4;
endpackage

// File: rtl/mul_issue_scheduler_scoreboard.sv
// mul_scoreboard: shift scoreboard aligned to multiplier stages plus hazard match
module mul_scoreboard #(
  parameter int STAGES = 4,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_i,
  input  logic          wr_i,
  input  logic [AW-1:0] rd_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  output logic          rs1_hit_o,
  output logic          rs2_hit_o,
  output logic          rd_hit_o,
  output logic          ret_v_o,
  output logic          ret_occ_o,
  output logic [AW-1:0] ret_rd_o
);
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_occ;
  logic [AW-1:0]     r_rd [STAGES];
  // r_occ tracks every issue (incl. x0/no-write) so mul_done_i can be cross-checked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_occ <= '0;
      for (int k = 0; k < STAGES; k++) r_rd[k] <= '0;
    end else begin
      r_v <= {r_v[STAGES-2:0], issue_i & wr_i & (|rd_i)};
      r_occ <= {r_occ[STAGES-2:0], issue_i};
      r_rd[0] <= rd_i;
      for (int k = 1; k < STAGES; k++) r_rd[k] <= r_rd[k-1];
    end
  end
  always_comb begin
    rs1_hit_o = 1'b0;
    rs2_hit_o = 1'b0;
    rd_hit_o = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      rs1_hit_o = rs1_hit_o | (r_v[k] & (r_rd[k] == rs1_i));
      rs2_hit_o = rs2_hit_o | (r_v[k] & (r_rd[k] == rs2_i));
      rd_hit_o = rd_hit_o | (r_v[k] & (r_rd[k] == rd_i));
    end
  end
  assign ret_v_o = r_v[STAGES-1];
  assign ret_occ_o = r_occ[STAGES-1];
  assign ret_rd_o = r_rd[STAGES-1];
endmodule

// File: rtl/mul_issue_scheduler.sv
// mul_issue_scheduler: issue/hazard control, writeback arbitration and drain FSM
module mul_issue_scheduler
  import mul_issue_scheduler_pkg::*;
#(
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid_i,
  input  logic                  dec_is_m_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic                  dec_wr_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_i,
  input  logic                  dec_use_rs1_i,
  input  logic                  dec_use_rs2_i,
  output logic                  dec_stall_o,
  output logic                  mul_issue_o,
  input  logic                  mul_done_i,
  input  logic                  alu_wb_valid_i,
  output logic                  alu_wb_stall_o,
  output logic                  wb_sel_mul_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  input  logic                  drain_req_i,
  output logic                  drain_done_o,
  output logic [CNT_W-1:0]      inflight_o,
  output logic                  sync_err_o
);
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_sync_err;
  logic                  w_rs1_hit;
  logic                  w_rs2_hit;
  logic                  w_rd_hit;
  logic                  w_ret_v;
  logic                  w_ret_occ;
  logic [REG_ADDR_W-1:0] w_ret_rd;
  logic                  w_hazard;
  logic                  w_drain;
  logic                  w_issue;
  logic                  w_dec;
  logic                  w_zero;
  logic                  w_run;

  mul_scoreboard #(.STAGES(MUL_STAGES), .AW(REG_ADDR_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue_i   (w_issue),
    .wr_i      (dec_wr_i),
    .rd_i      (dec_rd_i),
    .rs1_i     (dec_rs1_i),
    .rs2_i     (dec_rs2_i),
    .rs1_hit_o (w_rs1_hit),
    .rs2_hit_o (w_rs2_hit),
    .rd_hit_o  (w_rd_hit),
    .ret_v_o   (w_ret_v),
    .ret_occ_o (w_ret_occ),
    .ret_rd_o  (w_ret_rd)
  );

  assign w_hazard = (dec_use_rs1_i & w_rs1_hit) | (dec_use_rs2_i & w_rs2_hit) | (dec_wr_i & w_rd_hit);
  // drain_req_i blocks issue in the same cycle it rises, before the FSM leaves BUSY.
  assign w_drain = drain_req_i | (r_state == ST_DRAIN) | (r_state == ST_DONE) | (r_state == ST_HOLD);
  assign w_issue = !rst & dec_valid_i & dec_is_m_i & !w_hazard & !w_drain;
  assign w_dec = mul_done_i & (|r_cnt);
  assign w_cnt_nxt = r_cnt + CNT_W'(w_issue) - CNT_W'(w_dec);
  assign w_zero = (w_cnt_nxt == '0);
  assign w_run = (r_state == ST_IDLE) | (r_state == ST_BUSY);

  assign mul_issue_o = w_issue;
  assign dec_stall_o = !rst & dec_valid_i & (w_hazard | (dec_is_m_i & w_drain));
  assign wb_sel_mul_o = !rst & mul_done_i & w_ret_v;
  assign wb_rd_o = wb_sel_mul_o ? w_ret_rd : '0;
  assign alu_wb_stall_o = wb_sel_mul_o & alu_wb_valid_i;
  assign drain_done_o = (r_state == ST_DONE);
  assign inflight_o = r_cnt;
  assign sync_err_o = r_sync_err;

  always_comb begin
    w_state_nxt = w_run ? (drain_req_i ? (w_zero ? ST_DONE : ST_DRAIN) : (w_zero ? ST_IDLE : ST_BUSY)) :
                  (r_state == ST_DRAIN) ? (w_zero ? ST_DONE : ST_DRAIN) :
                  (drain_req_i ? ST_HOLD : ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_sync_err <= r_sync_err | (mul_done_i != w_ret_occ);
    end
  end
endmodule
